mem_access: RTL

- Y86-64 memory stage; sits directly downstream of the execute stage.
- Consumes the execute result (valE, Cnd) together with icode, valA, valP and the destination register IDs.
- Issues at most one data-memory read or write per instruction over a request/acknowledge interface.
- Delivers valE, valM, the final dstE/dstM and a status code to writeback through a valid/ready pipeline register.

---
 rtl/mem_access.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// Y86-64 memory stage.
// Takes the execute result, performs at most one data-memory read or write
// over a request/acknowledge handshake, then presents the writeback bundle
// through a valid/ready register.
// Optional build macro: MEM_TIMEOUT_EN -- abort a request that has not been
// acknowledged within TIMEOUT cycles and report it as an address error.
module mem_access #(
  parameter int unsigned DW      = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  // execute -> memory
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    icode,
  input  logic          Cnd,
  input  logic [DW-1:0] valE,
  input  logic [DW-1:0] valA,
  input  logic [DW-1:0] valP,
  input  logic [3:0]    dstE,
  input  logic [3:0]    dstM,
  // data memory
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  // memory -> writeback
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    w_icode,
  output logic [DW-1:0] w_valE,
  output logic [DW-1:0] w_valM,
  output logic [3:0]    w_dstE,
  output logic [3:0]    w_dstM,
  output logic [2:0]    w_stat
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  logic [1:0]    state;

  // Decode of the incoming instruction
  logic          dec_ins;
  logic          dec_wr;
  logic          dec_rd;
  logic          dec_mem;
  logic          dec_misaligned;
  logic [DW-1:0] dec_addr;
  logic [DW-1:0] dec_wdata;
  logic [3:0]    dec_dstE;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt;
`endif

  // Handshake outputs follow the state; mem_req is also gated by rst so an
  // outstanding request is withdrawn in the very cycle reset is sampled.
  always_comb begin
    in_ready  = (state == IDLE);
    mem_req   = (state == REQ) && !rst;
    out_valid = (state == OUT);
  end

  // Classify the instruction and form the memory address/data
  always_comb begin
    dec_ins   = (icode >= 4'hC);
    dec_wr    = (icode == I_RMMOVQ) || (icode == I_PUSHQ) || (icode == I_CALL);
    dec_rd    = (icode == I_MRMOVQ) || (icode == I_POPQ)  || (icode == I_RET);
    dec_mem   = dec_wr || dec_rd;
    dec_addr  = ((icode == I_POPQ) || (icode == I_RET)) ? valA : valE;
    dec_wdata = (icode == I_CALL) ? valP : valA;
    dec_misaligned = (dec_addr[2:0] != 3'b000);
    // A conditional move whose condition failed writes nothing.
    dec_dstE  = ((icode == I_RRMOVQ) && !Cnd) ? REG_NONE : dstE;
  end

  // Stage FSM and the registered request / writeback bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      w_icode   <= I_HALT;
      w_valE    <= '0;
      w_valM    <= '0;
      w_dstE    <= REG_NONE;
      w_dstM    <= REG_NONE;
      w_stat    <= 3'd0;
`ifdef MEM_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            w_icode <= icode;
            w_valE  <= valE;
            w_valM  <= '0;
            w_dstE  <= dec_dstE;
            w_dstM  <= dstM;
`ifdef MEM_TIMEOUT_EN
            to_cnt  <= '0;
`endif
            if (dec_ins) begin
              w_stat <= STAT_INS;
              state  <= OUT;
            end else if (dec_mem && dec_misaligned) begin
              w_stat <= STAT_ADR;
              state  <= OUT;
            end else if (dec_mem) begin
              w_stat    <= STAT_AOK;
              mem_we    <= dec_wr;
              mem_addr  <= dec_addr;
              mem_wdata <= dec_wdata;
              state     <= REQ;
            end else begin
              w_stat <= STAT_AOK;
              state  <= OUT;
            end
          end
        end

        REQ: begin
          if (mem_ack) begin
            if (!mem_we) begin
              w_valM <= mem_rdata;
            end
            mem_we <= 1'b0;
            state  <= OUT;
          end
`ifdef MEM_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            w_stat <= STAT_ADR;
            w_valM <= '0;
            mem_we <= 1'b0;
            state  <= OUT;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end

        OUT: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
